// File: rtl/si_dequantizer_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : si_dequantizer_seq_if
// Description : Valid/ready handshake bundle for the sequential dequantizer.
//               Input side carries the quantized value, output side carries
//               the wide-domain result and its saturation flag.
// Ports       : in_data/in_valid/in_ready   - quantized input channel
//               out_data/out_valid/out_ready - dequantized output channel
//               out_sat                      - result was clamped
// Revision    : 1.0 - initial release
// ============================================================================
interface si_dequantizer_seq_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 32
);
    logic [N_IN-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [N_OUT-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sat;

    // Producer/consumer side (drives inputs, samples results).
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sat
    );

    // Dequantizer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/si_dequantizer_seq.sv
`default_nettype none
// ============================================================================
// Module      : si_dequantizer_seq
// Description : Sequential dequantizer. Computes
//               (in - OFFSET) * M1_0Q32 * 2^SHIFT / 2^32, rounded half away
//               from zero and saturated to N_OUT bits, using a bit-serial
//               shift-add multiplier (one magnitude bit per cycle).
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - slave side of si_dequantizer_seq_if
//                        (in_data/in_valid/in_ready, out_data/out_valid/
//                         out_ready/out_sat)
// Revision    : 1.0 - initial release
// ============================================================================
module si_dequantizer_seq #(
    parameter int          N_IN    = 8,
    parameter int          N_OUT   = 32,
    parameter logic [31:0] M1_0Q32 = 32'h8000_0000,
    parameter int          SHIFT   = 10,
    parameter int          OFFSET  = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    si_dequantizer_seq_if.slave bus
);

    localparam int AW = N_IN + 32;              // accumulator width
    localparam int MW = AW + 1;                 // rounded magnitude width
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [N_IN:0]    c_OFF_EXT = (N_IN+1)'(OFFSET);
    localparam logic [MW-1:0]    c_POS_LIM = (MW'(1) << (N_OUT-1)) - MW'(1);
    localparam logic [MW-1:0]    c_NEG_LIM = MW'(1) << (N_OUT-1);
    localparam logic [N_OUT-1:0] c_MAX     = {1'b0, {(N_OUT-1){1'b1}}};
    localparam logic [N_OUT-1:0] c_MIN     = {1'b1, {(N_OUT-1){1'b0}}};
    localparam logic [CW-1:0]    c_LAST    = CW'(N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              neg_q, neg_d;
    logic [N_IN-1:0]   mag_q, mag_d;
    logic [AW-1:0]     mcand_q, mcand_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_OUT-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sat_q, out_sat_d;

    // Zero-point removal at N_IN+1 bits so the full difference range fits.
    logic [N_IN:0]     w_diff;
    logic [N_IN-1:0]   w_mag;
    // Rounding: keep the bits above 2^(32-SHIFT), add the first dropped bit.
    // Working on the magnitude makes this half-away-from-zero for both signs.
    logic [AW-1:0]     w_q;
    logic              w_r;
    logic [MW-1:0]     w_m;

    assign w_diff = {bus.in_data[N_IN-1], bus.in_data} - c_OFF_EXT;
    assign w_mag  = w_diff[N_IN] ? N_IN'(-w_diff) : w_diff[N_IN-1:0];
    assign w_q    = acc_q >> (32 - SHIFT);
    assign w_r    = acc_q[31 - SHIFT];
    assign w_m    = {1'b0, w_q} + MW'(w_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    neg_d   = w_diff[N_IN];
                    mag_d   = w_mag;
                    mcand_d = AW'(M1_0Q32);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                // LSB-first: the multiplicand doubles as the magnitude is
                // consumed, so no variable shifter is needed.
                if (mag_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mag_d   = mag_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == c_LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                out_sat_d = 1'b0;
                if (!neg_q) begin
                    if (w_m > c_POS_LIM) begin
                        out_data_d = c_MAX;
                        out_sat_d  = 1'b1;
                    end else begin
                        out_data_d = w_m[N_OUT-1:0];
                    end
                end else begin
                    // Magnitude 2^(N_OUT-1) is exactly MIN and not a clamp.
                    if (w_m > c_NEG_LIM) begin
                        out_data_d = c_MIN;
                        out_sat_d  = 1'b1;
                    end else begin
                        out_data_d = (~w_m[N_OUT-1:0]) + N_OUT'(1);
                    end
                end
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs come from registers; in_ready is decoded from state only.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_si_dequantizer_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_si_dequantizer_seq
// Description : Self-checking bench for si_dequantizer_seq. Three instances
//               cover the default, rounding (SHIFT=0) and saturation
//               (N_OUT=16, M1=0xFFFFFFFF) configurations. Expected results
//               go into a scoreboard queue at input acceptance and are
//               popped when the output handshake is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_si_dequantizer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [7:0]        din;
    logic              iv   [3];
    logic              ordy [3];
    logic              ir   [3];
    logic              ov   [3];
    logic              os   [3];
    logic signed [31:0] od  [3];

    si_dequantizer_seq_if #(.N_IN(8), .N_OUT(32)) bus0 ();
    si_dequantizer_seq_if #(.N_IN(8), .N_OUT(32)) bus1 ();
    si_dequantizer_seq_if #(.N_IN(8), .N_OUT(16)) bus2 ();

    assign bus0.in_data = din;  assign bus0.in_valid = iv[0]; assign bus0.out_ready = ordy[0];
    assign bus1.in_data = din;  assign bus1.in_valid = iv[1]; assign bus1.out_ready = ordy[1];
    assign bus2.in_data = din;  assign bus2.in_valid = iv[2]; assign bus2.out_ready = ordy[2];

    assign ir[0] = bus0.in_ready; assign ov[0] = bus0.out_valid; assign os[0] = bus0.out_sat;
    assign ir[1] = bus1.in_ready; assign ov[1] = bus1.out_valid; assign os[1] = bus1.out_sat;
    assign ir[2] = bus2.in_ready; assign ov[2] = bus2.out_valid; assign os[2] = bus2.out_sat;
    assign od[0] = bus0.out_data;
    assign od[1] = bus1.out_data;
    assign od[2] = {{16{bus2.out_data[15]}}, bus2.out_data};

    si_dequantizer_seq #(.N_IN(8), .N_OUT(32), .M1_0Q32(32'h8000_0000), .SHIFT(10), .OFFSET(22))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    si_dequantizer_seq #(.N_IN(8), .N_OUT(32), .M1_0Q32(32'h8000_0000), .SHIFT(0), .OFFSET(22))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    si_dequantizer_seq #(.N_IN(8), .N_OUT(16), .M1_0Q32(32'hFFFF_FFFF), .SHIFT(10), .OFFSET(22))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        int         sel;
        logic [7:0] din;
        int         data;
        bit         sat;
    } vec_t;

    typedef struct {
        int sel;
        int data;
        bit sat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Arithmetic definition: round(mag * M1 * 2^SHIFT / 2^32) by adding half
    // an output LSB before truncating, then clamp to the signed range.
    function automatic void ref_model(input logic [7:0] x, input int off, input longint m1,
                                      input int sh, input int nout, output int y, output bit sat);
        longint d, mag, prod, m, lim;
        d    = longint'($signed(x)) - longint'(off);
        mag  = (d < 0) ? -d : d;
        prod = mag * m1;
        m    = (prod + (longint'(1) << (31 - sh))) >>> (32 - sh);
        lim  = (longint'(1) << (nout - 1)) - 1;
        sat  = 1'b0;
        if (d >= 0) begin
            if (m > lim) begin y = int'(lim); sat = 1'b1; end
            else y = int'(m);
        end else begin
            if (m > lim + 1) begin y = int'(-(lim + 1)); sat = 1'b1; end
            else y = int'(-m);
        end
    endfunction

    task automatic pop_cmp(input int sel);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("out_data", od[sel], e.data);
            chk("out_sat", os[sel], e.sat);
        end
    endtask

    // One transaction on instance sel, called and returning at a negedge.
    // hold > 0 keeps out_ready low that many cycles while pulsing in_valid.
    task automatic run_txn(input int sel, input logic [7:0] d, input int ed, input bit es,
                           input int hold);
        int   lat;
        exp_t e;
        chk("in_ready_idle", ir[sel], 1);
        din = d; iv[sel] = 1'b1; ordy[sel] = 1'b0;
        e.sel = sel; e.data = ed; e.sat = es;
        sb.push_back(e);
        @(negedge clk);
        iv[sel] = 1'b0;
        chk("in_ready_busy", ir[sel], 0);
        lat = 0;
        while (!ov[sel] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 9);
        for (int i = 0; i < hold; i++) begin
            iv[sel] = (i % 2 == 0);
            din     = 8'd5;
            @(negedge clk);
            chk("bp_out_valid", ov[sel], 1);
            chk("bp_out_data", od[sel], ed);
            chk("bp_in_ready", ir[sel], 0);
        end
        iv[sel]   = 1'b0;
        ordy[sel] = 1'b1;
        pop_cmp(sel);
        @(negedge clk);
        ordy[sel] = 1'b0;
        chk("post_hs_out_valid", ov[sel], 0);
        chk("post_hs_in_ready", ir[sel], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        int   sent, got, cyc, yv;
        bit   sv, no_out, excl_bad;
        exp_t e;

        tbl[0]  = '{0, 8'd122, 51200,  1'b0};
        tbl[1]  = '{0, 8'd22,  0,      1'b0};
        tbl[2]  = '{0, 8'h80,  -76800, 1'b0};
        tbl[3]  = '{0, 8'd127, 53760,  1'b0};
        tbl[4]  = '{1, 8'd25,  2,      1'b0};
        tbl[5]  = '{1, 8'd19,  -2,     1'b0};
        tbl[6]  = '{1, 8'd24,  1,      1'b0};
        tbl[7]  = '{1, 8'h80,  -75,    1'b0};
        tbl[8]  = '{1, 8'd127, 53,     1'b0};
        tbl[9]  = '{1, 8'd21,  -1,     1'b0};
        tbl[10] = '{2, 8'd122, 32767,  1'b1};
        tbl[11] = '{2, 8'hB2,  -32768, 1'b1};
        tbl[12] = '{2, 8'd54,  32767,  1'b1};
        tbl[13] = '{2, 8'hF6,  -32768, 1'b0};
        tbl[14] = '{2, 8'd53,  31744,  1'b0};
        tbl[15] = '{2, 8'd22,  0,      1'b0};

        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b0;
        end
        din   = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", ir[0], 1);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_out_data", od[0], 0);
        chk("rst_out_sat", os[0], 0);
        chk("rst_out_data_n16", od[2], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors across the three configurations.
        for (int i = 0; i < 16; i++) begin
            run_txn(tbl[i].sel, tbl[i].din, tbl[i].data, tbl[i].sat, 0);
        end

        // Backpressure: 5 stalled cycles with in_valid pulses, then one transfer.
        run_txn(0, 8'd122, 51200, 1'b0, 5);
        ordy[0] = 1'b1;
        no_out  = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ov[0]) no_out = 1'b0;
        end
        ordy[0] = 1'b0;
        chk("bp_single_transfer", no_out, 1);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset in the middle of the multiply.
        din = 8'd122; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("busy_before_rst", ir[0], 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", ir[0], 1);
        chk("async_rst_out_valid", ov[0], 0);
        chk("async_rst_out_data", od[0], 0);
        chk("async_rst_out_sat", os[0], 0);
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[0] = 1'b1;
        no_out  = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (ov[0]) no_out = 1'b0;
        end
        ordy[0] = 1'b0;
        chk("aborted_no_output", no_out, 1);
        run_txn(0, 8'd122, 51200, 1'b0, 0);

        // Random back-to-back traffic against the reference model.
        sent = 0; got = 0; cyc = 0; excl_bad = 1'b0;
        while (got < 20 && cyc < 4000) begin
            if (sent < 20 && $urandom_range(0, 2) != 0) begin
                iv[0] = 1'b1;
                din   = 8'($urandom);
            end else begin
                iv[0] = 1'b0;
            end
            ordy[0] = ($urandom_range(0, 3) != 0);
            if (ir[0] && ov[0]) excl_bad = 1'b1;
            if (iv[0] && ir[0]) begin
                ref_model(din, 22, 64'h8000_0000, 10, 32, yv, sv);
                e.sel = 0; e.data = yv; e.sat = sv;
                sb.push_back(e);
                sent++;
            end
            if (ov[0] && ordy[0]) begin
                pop_cmp(0);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b0;
        chk("rand_results", got, 20);
        chk("rand_sb_empty", sb.size(), 0);
        chk("rdy_vld_exclusive", excl_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
